wb_bar_graph_slave: RTL and testbench

//   Wishbone classic slave that sits on one intercon slave port (wbi_* side) and drives an LED bar graph.

---
 rtl/bar_graph_pkg.sv | 20 ++
 rtl/wb_bar_graph_slave_if.sv | 25 ++
 rtl/bar_pwm.sv | 48 ++++
 rtl/wb_bar_graph_slave.sv | 101 ++++++++++
 tb/tb_wb_bar_graph_slave.sv | 376 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bar_graph_pkg.sv
// Shared definitions for the Wishbone LED bar-graph slave: register map, CTRL bits, bus FSM states.
package bar_graph_pkg;

  localparam logic [1:0] REG_CTRL    = 2'd0;
  localparam logic [1:0] REG_PATTERN = 2'd1;
  localparam logic [1:0] REG_LEVEL   = 2'd2;
  localparam logic [1:0] REG_BRIGHT  = 2'd3;

  localparam int unsigned CTRL_EN    = 0;
  localparam int unsigned CTRL_MODE  = 1;
  localparam int unsigned CTRL_INV   = 2;
  localparam int unsigned CTRL_BITS  = 3;
  localparam int unsigned LEVEL_BITS = 8;

  typedef enum logic {
    S_IDLE,
    S_ACK
  } bus_state_e;

endpackage

// File: rtl/wb_bar_graph_slave_if.sv
// Wishbone classic slave-port signal bundle between the intercon and the bar-graph slave.
interface wb_bar_graph_slave_if #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 16
) ();

  logic [ADDR_WIDTH-1:0] wbs_address;
  logic [DATA_WIDTH-1:0] wbs_writedata;
  logic [DATA_WIDTH-1:0] wbs_readdata;
  logic                  wbs_write;
  logic                  wbs_cycle;
  logic                  wbs_strobe;
  logic                  wbs_ack;

  modport master (
    output wbs_address, wbs_writedata, wbs_write, wbs_cycle, wbs_strobe,
    input  wbs_readdata, wbs_ack
  );

  modport slave (
    input  wbs_address, wbs_writedata, wbs_write, wbs_cycle, wbs_strobe,
    output wbs_readdata, wbs_ack
  );

endinterface

// File: rtl/bar_pwm.sv
// LED datapath: pattern/thermometer select, optional invert, PWM gating and the registered led output.
module bar_pwm
  import bar_graph_pkg::*;
#(
  parameter int unsigned NUM_LEDS  = 8,
  parameter int unsigned PWM_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [CTRL_BITS-1:0]  ctrl,
  input  logic [NUM_LEDS-1:0]   pattern,
  input  logic [LEVEL_BITS-1:0] level,
  input  logic [PWM_WIDTH-1:0]  bright,
  output logic [NUM_LEDS-1:0]   led
);

  logic [PWM_WIDTH-1:0] pwm_cnt_q;
  logic [NUM_LEDS-1:0]  therm;
  logic [NUM_LEDS-1:0]  bar;
  logic [NUM_LEDS-1:0]  led_d;
  logic                 pwm_on;

  // Bit i lit when level exceeds i, so levels >= NUM_LEDS saturate to all on.
  always_comb begin
    therm = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      therm[i] = (32'(level) > 32'(i));
    end
  end

  always_comb begin
    bar    = ctrl[CTRL_MODE] ? therm : pattern;
    bar    = ctrl[CTRL_INV] ? ~bar : bar;
    pwm_on = (pwm_cnt_q < bright);
    led_d  = ctrl[CTRL_EN] ? (bar & {NUM_LEDS{pwm_on}}) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_cnt_q <= '0;
      led       <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + 1'b1;
      led       <= led_d;
    end
  end

endmodule

// File: rtl/wb_bar_graph_slave.sv
// Wishbone classic slave holding the four bar-graph control registers; LED generation is in bar_pwm.
module wb_bar_graph_slave
  import bar_graph_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_LEDS   = 8,
  parameter int unsigned PWM_WIDTH  = 8
) (
  input  logic                clk,
  input  logic                reset,
  wb_bar_graph_slave_if.slave wbs,
  output logic [NUM_LEDS-1:0] led
);

  bus_state_e            state_q;
  logic                  ack_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] rdata_d;
  logic [CTRL_BITS-1:0]  ctrl_q;
  logic [NUM_LEDS-1:0]   pattern_q;
  logic [LEVEL_BITS-1:0] level_q;
  logic [PWM_WIDTH-1:0]  bright_q;
  logic [1:0]            reg_sel;
  logic                  unused_bits;

  assign reg_sel = wbs.wbs_address[1:0];
  // Only the word index and the low register bits are decoded.
  assign unused_bits = ^{wbs.wbs_address, wbs.wbs_writedata};

  always_comb begin
    rdata_d = '0;
    unique case (reg_sel)
      REG_CTRL:    rdata_d[CTRL_BITS-1:0]  = ctrl_q;
      REG_PATTERN: rdata_d[NUM_LEDS-1:0]   = pattern_q;
      REG_LEVEL:   rdata_d[LEVEL_BITS-1:0] = level_q;
      REG_BRIGHT:  rdata_d[PWM_WIDTH-1:0]  = bright_q;
      default:     rdata_d = '0;
    endcase
  end

  // ACK always falls back to IDLE, so a held request completes every second cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ack_q     <= 1'b0;
      rdata_q   <= '0;
      ctrl_q    <= '0;
      pattern_q <= '0;
      level_q   <= '0;
      bright_q  <= '1;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (wbs.wbs_cycle && wbs.wbs_strobe) begin
            state_q <= S_ACK;
            ack_q   <= 1'b1;
            if (wbs.wbs_write) begin
              unique case (reg_sel)
                REG_CTRL:    ctrl_q    <= wbs.wbs_writedata[CTRL_BITS-1:0];
                REG_PATTERN: pattern_q <= wbs.wbs_writedata[NUM_LEDS-1:0];
                REG_LEVEL:   level_q   <= wbs.wbs_writedata[LEVEL_BITS-1:0];
                REG_BRIGHT:  bright_q  <= wbs.wbs_writedata[PWM_WIDTH-1:0];
                default:     ;
              endcase
            end else begin
              rdata_q <= rdata_d;
            end
          end
        end
        S_ACK: begin
          state_q <= S_IDLE;
          ack_q   <= 1'b0;
          rdata_q <= '0;
        end
        default: begin
          state_q <= S_IDLE;
          ack_q   <= 1'b0;
          rdata_q <= '0;
        end
      endcase
    end
  end

  assign wbs.wbs_ack      = ack_q;
  assign wbs.wbs_readdata = rdata_q;

  bar_pwm #(
    .NUM_LEDS  (NUM_LEDS),
    .PWM_WIDTH (PWM_WIDTH)
  ) u_bar_pwm (
    .clk     (clk),
    .reset   (reset),
    .ctrl    (ctrl_q),
    .pattern (pattern_q),
    .level   (level_q),
    .bright  (bright_q),
    .led     (led)
  );

endmodule

// File: tb/tb_wb_bar_graph_slave.sv
// Self-checking bench for wb_bar_graph_slave: read scoreboard queue plus a PWM counter model for led.
module tb_wb_bar_graph_slave;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] led;
  logic [7:0] m_cnt;
  logic [15:0] exp_q[$];
  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  wb_bar_graph_slave_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) bus ();

  wb_bar_graph_slave #(
    .ADDR_WIDTH (16),
    .DATA_WIDTH (16),
    .NUM_LEDS   (8),
    .PWM_WIDTH  (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .wbs   (bus),
    .led   (led)
  );

  // Independent PWM counter model.
  always @(posedge clk) begin
    if (reset) m_cnt <= 8'd0;
    else       m_cnt <= m_cnt + 8'd1;
  end

  // Sampled #1 after an edge: led reflects the counter value from before that edge.
  function automatic logic [7:0] led_model(input logic [7:0] bar, input bit en,
                                           input logic [7:0] bright);
    logic [7:0] prev;
    prev = m_cnt - 8'd1;
    return (en && (prev < bright)) ? bar : 8'h00;
  endfunction

  task automatic bus_idle();
    bus.wbs_address   = '0;
    bus.wbs_writedata = '0;
    bus.wbs_write     = 1'b0;
    bus.wbs_cycle     = 1'b0;
    bus.wbs_strobe    = 1'b0;
  endtask

  // Single transfer; returns ack before, at and after the acking edge, plus read data.
  task automatic bus_xfer(input bit wr, input logic [1:0] a, input logic [15:0] d,
                          output logic ack0, output logic ack1, output logic [15:0] rd,
                          output logic ack2);
    @(negedge clk);
    bus.wbs_address   = {14'd0, a};
    bus.wbs_writedata = d;
    bus.wbs_write     = wr;
    bus.wbs_cycle     = 1'b1;
    bus.wbs_strobe    = 1'b1;
    ack0 = bus.wbs_ack;
    @(posedge clk); #1;
    ack1 = bus.wbs_ack;
    rd   = bus.wbs_readdata;
    bus_idle();
    @(posedge clk); #1;
    ack2 = bus.wbs_ack;
  endtask

  task automatic test_reset();
    logic a0, a1, a2;
    logic [15:0] rd, e;
    reset = 1'b1;
    bus_idle();
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({bus.wbs_ack, bus.wbs_readdata, led} !== 25'd0)
      $display("FAIL reset_state: got ack=%b rd=%h led=%h, want 0/0000/00",
               bus.wbs_ack, bus.wbs_readdata, led);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back((i == 3) ? 16'h00FF : 16'h0000);
      bus_xfer(1'b0, 2'(i), 16'h0, a0, a1, rd, a2);
      e = exp_q.pop_front();
      vectors++;
      if ({a0, a1, a2} !== 3'b010)
        $display("FAIL reset_read_ack reg%0d: got %b, want 010", i, {a0, a1, a2});
      vectors++;
      if (rd !== e) $display("FAIL reset_read reg%0d: got %h, want %h", i, rd, e);
      vectors++;
      if (led !== 8'h00) $display("FAIL reset_led reg%0d: got %h, want 00", i, led);
    end
    if (0) miscompares++;
  endtask

  task automatic write_reg(input logic [1:0] a, input logic [15:0] d);
    logic a0, a1, a2;
    logic [15:0] rd;
    bus_xfer(1'b1, a, d, a0, a1, rd, a2);
    vectors++;
    if ({a0, a1, a2} !== 3'b010) begin
      miscompares++;
      $display("FAIL write_ack reg%0d: got %b, want 010", a, {a0, a1, a2});
    end
  endtask

  task automatic test_pattern();
    logic a0, a1, a2;
    logic [15:0] rd, e;
    logic [7:0] el;
    int on;
    write_reg(2'd0, 16'h0001);
    write_reg(2'd1, 16'h00A5);
    write_reg(2'd3, 16'h00FF);
    exp_q.push_back(16'h00A5);
    bus_xfer(1'b0, 2'd1, 16'h0, a0, a1, rd, a2);
    e = exp_q.pop_front();
    vectors++;
    if (rd !== e) begin
      miscompares++;
      $display("FAIL pattern_readback: got %h, want %h", rd, e);
    end
    on = 0;
    for (int c = 0; c < 256; c++) begin
      @(posedge clk); #1;
      el = led_model(8'hA5, 1'b1, 8'hFF);
      vectors++;
      if (led !== el) begin
        miscompares++;
        $display("FAIL pattern_led cyc%0d: got %h, want %h", c, led, el);
      end
      if (led === 8'hA5) on++;
    end
    vectors++;
    if (on != 255) begin
      miscompares++;
      $display("FAIL pattern_duty: got %0d on-cycles, want 255", on);
    end
  endtask

  task automatic test_level();
    logic [15:0] lv[3] = '{16'd3, 16'd0, 16'd200};
    logic [7:0]  bv[3] = '{8'h07, 8'h00, 8'hFF};
    logic [7:0] el;
    write_reg(2'd0, 16'h0003);
    for (int k = 0; k < 3; k++) begin
      write_reg(2'd2, lv[k]);
      for (int c = 0; c < 20; c++) begin
        @(posedge clk); #1;
        el = led_model(bv[k], 1'b1, 8'hFF);
        vectors++;
        if (led !== el) begin
          miscompares++;
          $display("FAIL level_led lvl=%0d: got %h, want %h", lv[k], led, el);
        end
      end
    end
  endtask

  task automatic test_readback_masking();
    logic [1:0]  ra[3] = '{2'd0, 2'd2, 2'd1};
    logic [15:0] wd[3] = '{16'hFFFF, 16'h1234, 16'hFFA5};
    logic [15:0] ed[3] = '{16'h0007, 16'h0034, 16'h00A5};
    logic a0, a1, a2;
    logic [15:0] rd, e;
    for (int k = 0; k < 3; k++) begin
      write_reg(ra[k], wd[k]);
      exp_q.push_back(ed[k]);
      bus_xfer(1'b0, ra[k], 16'h0, a0, a1, rd, a2);
      e = exp_q.pop_front();
      vectors++;
      if (rd !== e || a1 !== 1'b1) begin
        miscompares++;
        $display("FAIL mask_readback reg%0d: got %h ack=%b, want %h ack=1", ra[k], rd, a1, e);
      end
    end
  endtask

  task automatic test_invert();
    logic [7:0] el;
    write_reg(2'd0, 16'h0007);
    write_reg(2'd2, 16'h0002);
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      el = led_model(8'hFC, 1'b1, 8'hFF);
      vectors++;
      if (led !== el) begin
        miscompares++;
        $display("FAIL invert_led: got %h, want %h", led, el);
      end
    end
    write_reg(2'd3, 16'h0000);
    for (int c = 0; c < 300; c++) begin
      @(posedge clk); #1;
      vectors++;
      if (led !== 8'h00) begin
        miscompares++;
        $display("FAIL bright0_led cyc%0d: got %h, want 00", c, led);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] e;
    @(negedge clk);
    bus.wbs_address = 16'd1;
    bus.wbs_write   = 1'b0;
    bus.wbs_cycle   = 1'b1;
    bus.wbs_strobe  = 1'b1;
    repeat (3) exp_q.push_back(16'h00A5);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      vectors++;
      if (bus.wbs_ack !== 1'((k % 2) == 1)) begin
        miscompares++;
        $display("FAIL b2b_ack k=%0d: got %b, want %0d", k, bus.wbs_ack, k % 2);
      end
      e = (bus.wbs_ack === 1'b1 && exp_q.size() > 0) ? exp_q.pop_front() : 16'h0000;
      vectors++;
      if (bus.wbs_readdata !== e) begin
        miscompares++;
        $display("FAIL b2b_data k=%0d: got %h, want %h", k, bus.wbs_readdata, e);
      end
    end
    bus_idle();
    @(posedge clk); #1;
    vectors++;
    if (bus.wbs_ack !== 1'b0 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL b2b_end: got ack=%b pending=%0d, want ack=0 pending=0",
               bus.wbs_ack, exp_q.size());
    end
  endtask

  task automatic test_no_transfer();
    logic a0, a1, a2;
    logic [15:0] rd, e;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      bus.wbs_address   = 16'd1;
      bus.wbs_writedata = 16'h000F;
      bus.wbs_write     = 1'b1;
      bus.wbs_cycle     = (k == 1);
      bus.wbs_strobe    = (k == 0);
      for (int c = 0; c < 3; c++) begin
        @(posedge clk); #1;
        vectors++;
        if (bus.wbs_ack !== 1'b0) begin
          miscompares++;
          $display("FAIL no_xfer_ack case%0d: got %b, want 0", k, bus.wbs_ack);
        end
      end
      bus_idle();
    end
    exp_q.push_back(16'h00A5);
    bus_xfer(1'b0, 2'd1, 16'h0, a0, a1, rd, a2);
    e = exp_q.pop_front();
    vectors++;
    if (rd !== e) begin
      miscompares++;
      $display("FAIL no_xfer_reg: got %h, want %h", rd, e);
    end
  endtask

  task automatic test_reset_abort();
    logic a0, a1, a2;
    logic [15:0] rd, e;
    @(negedge clk);
    bus.wbs_address   = 16'd1;
    bus.wbs_writedata = 16'h005A;
    bus.wbs_write     = 1'b1;
    bus.wbs_cycle     = 1'b1;
    bus.wbs_strobe    = 1'b1;
    reset             = 1'b1;
    @(posedge clk); #1;
    bus_idle();
    vectors++;
    if (bus.wbs_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_ack_edge: got %b, want 0", bus.wbs_ack);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      vectors++;
      if (bus.wbs_ack !== 1'b0 || led !== 8'h00) begin
        miscompares++;
        $display("FAIL abort_after: got ack=%b led=%h, want 0/00", bus.wbs_ack, led);
      end
    end
    exp_q.push_back(16'h0000);
    bus_xfer(1'b0, 2'd1, 16'h0, a0, a1, rd, a2);
    e = exp_q.pop_front();
    vectors++;
    if (rd !== e || a1 !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_pattern: got %h ack=%b, want %h ack=1", rd, a1, e);
    end
    exp_q.push_back(16'h00FF);
    bus_xfer(1'b0, 2'd3, 16'h0, a0, a1, rd, a2);
    e = exp_q.pop_front();
    vectors++;
    if (rd !== e) begin
      miscompares++;
      $display("FAIL abort_bright: got %h, want %h", rd, e);
    end
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      vectors++;
      if (led !== 8'h00) begin
        miscompares++;
        $display("FAIL abort_led: got %h, want 00", led);
      end
    end
  endtask

  // test_reset prints its own FAIL lines; count them by re-checking its summary in-line.
  int pre_fail;

  initial begin
    reset = 1'b1;
    bus_idle();
    test_reset_counted();
    test_pattern();
    test_level();
    test_readback_masking();
    test_invert();
    test_back_to_back();
    test_no_transfer();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  task automatic test_reset_counted();
    logic a0, a1, a2;
    logic [15:0] rd, e;
    reset = 1'b1;
    bus_idle();
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({bus.wbs_ack, bus.wbs_readdata, led} !== 25'd0) begin
      miscompares++;
      $display("FAIL reset_state: got ack=%b rd=%h led=%h, want 0/0000/00",
               bus.wbs_ack, bus.wbs_readdata, led);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back((i == 3) ? 16'h00FF : 16'h0000);
      bus_xfer(1'b0, 2'(i), 16'h0, a0, a1, rd, a2);
      e = exp_q.pop_front();
      vectors++;
      if ({a0, a1, a2} !== 3'b010) begin
        miscompares++;
        $display("FAIL reset_read_ack reg%0d: got %b, want 010", i, {a0, a1, a2});
      end
      vectors++;
      if (rd !== e) begin
        miscompares++;
        $display("FAIL reset_read reg%0d: got %h, want %h", i, rd, e);
      end
      vectors++;
      if (led !== 8'h00) begin
        miscompares++;
        $display("FAIL reset_led reg%0d: got %h, want 00", i, led);
      end
    end
  endtask

endmodule
